// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its read-side peers:
// FSM state encoding, the layout of the tagged FIFO word and a clog2 helper.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // Ceiling log2, usable in constant expressions (parameter derivation).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Tagged FIFO word is {last, chn, data}: the last flag sits above the channel field.
  function automatic int last_bit(input int data_width, input int chn_bits);
    return data_width + chn_bits;
  endfunction

  // The channel field starts right above the payload.
  function automatic int chn_lsb(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Channel-side and FIFO-side handshake bundle of the write arbiter.
// master = the arbiter, slave = staging buffers plus FIFO write port.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CHN    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int CHN_BITS  = clog2(NUM_CHN);
  localparam int WORD_BITS = DATA_WIDTH + CHN_BITS + 1;

  logic [NUM_CHN-1:0]            chn_req;
  logic [NUM_CHN*DATA_WIDTH-1:0] chn_data;
  logic [NUM_CHN-1:0]            chn_rd;
  logic                          fifo_half_empty;
  logic                          fifo_we;
  logic [WORD_BITS-1:0]          fifo_data;

  modport master (
    input  chn_req, chn_data, fifo_half_empty,
    output chn_rd, fifo_we, fifo_data
  );

  modport slave (
    output chn_req, chn_data, fifo_half_empty,
    input  chn_rd, fifo_we, fifo_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: picks the first requester at or after last+1
// (mod NUM_CHN), so the most recent winner always ranks lowest.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_CHN  = 4,
  localparam int CHN_BITS = clog2(NUM_CHN)
) (
  input  logic [NUM_CHN-1:0]  req,
  input  logic [CHN_BITS-1:0] last,
  output logic [CHN_BITS-1:0] gnt,
  output logic                any
);

  // Walk the channels starting one past the previous winner; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value held over from the previous evaluation, which would be a latch.
    gnt = '0;
    any = 1'b0;
    for (int i = 1; i <= NUM_CHN; i++) begin
      int idx;
      idx = int'(last) + i;
      if (idx >= NUM_CHN) idx = idx - NUM_CHN;
      if (!any && req[idx]) begin
        gnt = CHN_BITS'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: grants whole BURST_LEN bursts from one of
// NUM_CHN FWFT staging buffers into a shared clock-crossing FIFO, tagging each
// word with its channel and an end-of-burst flag. A burst only starts while
// the FIFO reports half_empty; once started it always runs to completion.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_CHN    = 4,
  parameter int  DATA_WIDTH = 16,
  parameter int  BURST_LEN  = 8,
  localparam int CHN_BITS   = clog2(NUM_CHN)
) (
  input  logic                wclk,
  input  logic                rst,
  input  logic                wrst,
  input  logic                en,
  output logic                busy,
  output logic [CHN_BITS-1:0] cur_chn,
  fifo_wr_arbiter_if.master   bus
);

  localparam int LAST_BIT  = last_bit(DATA_WIDTH, CHN_BITS);
  localparam int CHN_LSB   = chn_lsb(DATA_WIDTH);
  localparam int WORD_BITS = DATA_WIDTH + CHN_BITS + 1;
  localparam int CNT_BITS  = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;

  arb_state_t            state, state_nxt;
  logic [CNT_BITS-1:0]   cnt, cnt_nxt;
  logic [CHN_BITS-1:0]   chn_nxt;
  logic [CHN_BITS-1:0]   pick_gnt;
  logic                  pick_any;
  logic [WORD_BITS-1:0]  word;
  logic                  we_q;
  logic [WORD_BITS-1:0]  data_q;

  rr_pick #(
    .NUM_CHN (NUM_CHN)
  ) u_pick (
    .req  (bus.chn_req),
    .last (cur_chn),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  // Next-state logic: arbitration in ARB, fixed-length burst, one-cycle GAP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    chn_nxt   = cur_chn;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = ARB;
      end
      ARB: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (bus.fifo_half_empty && pick_any) begin
          chn_nxt   = pick_gnt;
          cnt_nxt   = CNT_BITS'(BURST_LEN - 1);
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (cnt == '0) state_nxt = GAP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      GAP: begin
        state_nxt = en ? ARB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM registers; cur_chn resets to the top channel so channel 0 wins first.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_chn <= CHN_BITS'(NUM_CHN - 1);
    end else if (wrst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_chn <= CHN_BITS'(NUM_CHN - 1);
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order or other blocks.
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_chn <= chn_nxt;
    end
  end

  // Pop strobe for the granted channel while the burst runs.
  always_comb begin
    bus.chn_rd = '0;
    if (state == BURST) bus.chn_rd[cur_chn] = 1'b1;
  end

  // Tag the popped head word with its channel and the end-of-burst flag.
  always_comb begin
    word                       = '0;
    word[LAST_BIT]             = (cnt == '0);
    word[CHN_LSB +: CHN_BITS]  = cur_chn;
    word[DATA_WIDTH-1:0]       = bus.chn_data[int'(cur_chn)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Output register: the FIFO sees each popped word exactly one cycle later.
  // A reset drops whatever word was in flight, so a truncated burst has no last.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      data_q <= '0;
    end else if (wrst) begin
      we_q   <= 1'b0;
      data_q <= '0;
    end else begin
      we_q   <= (state == BURST);
      data_q <= (state == BURST) ? word : '0;
    end
  end

  assign bus.fifo_we   = we_q;
  assign bus.fifo_data = data_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural FWFT sources per channel, a queue of
// expected FIFO words filled from the known grant order, and one task per scenario.
module tb_fifo_wr_arbiter;

  localparam int NUM_CHN    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int BURST_LEN  = 8;
  localparam int CHN_BITS   = 2;
  localparam int FW         = DATA_WIDTH + CHN_BITS + 1;
  localparam logic [15:0] SRC_BASE [NUM_CHN] = '{16'h0A00, 16'h0B00, 16'h0100, 16'h0D00};

  logic                wclk;
  logic                rst;
  logic                wrst;
  logic                en;
  logic                busy;
  logic [CHN_BITS-1:0] cur_chn;
  logic                src_clr;
  logic [15:0]         pops [NUM_CHN];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [FW-1:0]      sb [$];
  logic [NUM_CHN-1:0] rd_now;
  logic [NUM_CHN-1:0] rd_prev;

  fifo_wr_arbiter_if #(.NUM_CHN(NUM_CHN), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_CHN    (NUM_CHN),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .wclk    (wclk),
    .rst     (rst),
    .wrst    (wrst),
    .en      (en),
    .busy    (busy),
    .cur_chn (cur_chn),
    .bus     (bus)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  // FWFT sources: head word is base + number of words already popped.
  always @(posedge wclk) begin
    for (int k = 0; k < NUM_CHN; k++) begin
      if (src_clr)             pops[k] <= '0;
      else if (bus.chn_rd[k])  pops[k] <= pops[k] + 16'd1;
    end
  end

  always_comb begin
    bus.chn_data = '0;
    for (int k = 0; k < NUM_CHN; k++)
      bus.chn_data[k*DATA_WIDTH +: DATA_WIDTH] = SRC_BASE[k] + pops[k];
  end

  // One cycle: sample at the falling edge and retire any FIFO write against the queue.
  task automatic tick();
    logic [FW-1:0] exp;
    rd_prev = rd_now;
    @(negedge wclk);
    cyc++;
    rd_now = bus.chn_rd;
    if (bus.fifo_we === 1'b1) begin
      checks++;
      if (rd_prev == '0) begin
        errors++;
        $display("FAIL we_latency cyc=%0d fifo_we=1 but chn_rd was 0 in previous cycle", cyc);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got %h required no write", cyc, bus.fifo_data);
      end else begin
        exp = sb.pop_front();
        if (bus.fifo_data !== exp) begin
          errors++;
          $display("FAIL fifo_data cyc=%0d got %h required %h", cyc, bus.fifo_data, exp);
        end
      end
    end
  endtask

  task automatic push_burst(input int chn, input int first, input int n);
    logic [FW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = '0;
      w[FW-1] = (i == BURST_LEN - 1);
      w[DATA_WIDTH +: CHN_BITS] = CHN_BITS'(chn);
      w[DATA_WIDTH-1:0] = SRC_BASE[chn] + 16'(first + i);
      sb.push_back(w);
    end
  endtask

  task automatic wait_rd(input int budget, input string what);
    int n = 0;
    while (rd_now == '0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (rd_now == '0) begin
      errors++;
      $display("FAIL %s_start got no chn_rd within %0d cycles required a grant", what, budget);
    end
  endtask

  task automatic count_burst(input logic [NUM_CHN-1:0] mask, output int n);
    n = 0;
    while (rd_now == mask && n < 4 * BURST_LEN) begin
      n++;
      tick();
    end
  endtask

  task automatic drain(input string what);
    int n = 0;
    while (sb.size() != 0 && n < 4 * BURST_LEN) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d words unwritten required 0", what, sb.size());
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wrst = 1'b0;
    en = 1'b0;
    bus.chn_req = '0;
    bus.fifo_half_empty = 1'b1;
    src_clr = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    src_clr = 1'b0;
    sb.delete();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.chn_rd !== '0) begin errors++; $display("FAIL rst_chn_rd got %b required 0", bus.chn_rd); end
    checks++;
    if (bus.fifo_we !== 1'b0) begin errors++; $display("FAIL rst_fifo_we got %b required 0", bus.fifo_we); end
    checks++;
    if (bus.fifo_data !== '0) begin errors++; $display("FAIL rst_fifo_data got %h required 0", bus.fifo_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    checks++;
    if (cur_chn !== 2'd3) begin errors++; $display("FAIL rst_cur_chn got %0d required 3", cur_chn); end
    en = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL en_busy got %b required 1", busy); end
    wrst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wrst_busy got %b required 0", busy); end
    wrst = 1'b0;
    en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || cur_chn !== 2'd3 || bus.fifo_we !== 1'b0 || bus.chn_rd !== '0) begin
      errors++;
      $display("FAIL wrst_outputs got busy=%b cur_chn=%0d we=%b rd=%b required 0 3 0 0",
               busy, cur_chn, bus.fifo_we, bus.chn_rd);
    end
  endtask

  task automatic test_single_burst();
    int n;
    do_reset();
    push_burst(2, 0, BURST_LEN);
    bus.chn_req = 4'b0100;
    en = 1'b1;
    wait_rd(10, "single");
    checks++;
    if (rd_now !== 4'b0100) begin errors++; $display("FAIL single_rd_sel got %b required 0100", rd_now); end
    bus.chn_req = '0;
    count_burst(4'b0100, n);
    checks++;
    if (n != BURST_LEN) begin errors++; $display("FAIL single_rd_len got %0d required %0d", n, BURST_LEN); end
    drain("single");
    checks++;
    if (cur_chn !== 2'd2) begin errors++; $display("FAIL single_cur_chn got %0d required 2", cur_chn); end
  endtask

  task automatic test_rotation();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int exp_pop [NUM_CHN] = '{0, 0, 0, 0};
    int last_start = 0;
    int n;
    logic [NUM_CHN-1:0] m;
    do_reset();
    for (int g = 0; g < 6; g++) begin
      push_burst(order[g], exp_pop[order[g]], BURST_LEN);
      exp_pop[order[g]] += BURST_LEN;
    end
    bus.chn_req = '1;
    en = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_rd(12, "rotation");
      m = '0;
      m[order[g]] = 1'b1;
      checks++;
      if (rd_now !== m) begin errors++; $display("FAIL rotation_grant%0d got %b required %b", g, rd_now, m); end
      if (g > 0) begin
        checks++;
        if (cyc - last_start != BURST_LEN + 2) begin
          errors++;
          $display("FAIL rotation_period%0d got %0d required %0d", g, cyc - last_start, BURST_LEN + 2);
        end
      end
      last_start = cyc;
      if (g == 5) bus.chn_req = '0;
      count_burst(rd_now, n);
      checks++;
      if (n != BURST_LEN) begin errors++; $display("FAIL rotation_len%0d got %0d required %0d", g, n, BURST_LEN); end
    end
    drain("rotation");
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    bus.fifo_half_empty = 1'b0;
    bus.chn_req = 4'b0001;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (rd_now !== '0 || bus.fifo_we !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got rd=%b we=%b required 0 0", i, rd_now, bus.fifo_we);
      end
    end
    push_burst(0, 0, BURST_LEN);
    bus.fifo_half_empty = 1'b1;
    tick();
    checks++;
    if (rd_now !== 4'b0001) begin errors++; $display("FAIL bp_release got %b required 0001", rd_now); end
    tick();
    tick();
    bus.fifo_half_empty = 1'b0;
    count_burst(4'b0001, n);
    checks++;
    if (n + 2 != BURST_LEN) begin errors++; $display("FAIL bp_complete got %0d words required %0d", n + 2, BURST_LEN); end
    drain("bp");
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_now !== '0) begin errors++; $display("FAIL bp_rehold%0d got %b required 0", i, rd_now); end
    end
    bus.chn_req = '0;
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    push_burst(2, 0, BURST_LEN);
    bus.chn_req = 4'b0100;
    en = 1'b1;
    wait_rd(10, "enable");
    bus.chn_req = '0;
    tick();
    tick();
    tick();
    en = 1'b0;
    count_burst(4'b0100, n);
    checks++;
    if (n != BURST_LEN - 3) begin errors++; $display("FAIL en_remaining got %0d required %0d", n, BURST_LEN - 3); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL en_gap_busy got %b required 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL en_idle_busy got %b required 0", busy); end
    drain("enable");
    push_burst(3, 0, BURST_LEN);
    bus.chn_req = '1;
    en = 1'b1;
    wait_rd(10, "reenable");
    checks++;
    if (rd_now !== 4'b1000) begin errors++; $display("FAIL reenable_grant got %b required 1000", rd_now); end
    bus.chn_req = '0;
    count_burst(4'b1000, n);
    drain("reenable");
  endtask

  task automatic test_reset_mid_burst();
    int n;
    do_reset();
    push_burst(1, 0, 4);
    bus.chn_req = 4'b0010;
    en = 1'b1;
    wait_rd(10, "midrst");
    bus.chn_req = '0;
    for (int i = 0; i < 4; i++) tick();
    wrst = 1'b1;
    tick();
    checks++;
    if (rd_now !== '0 || bus.fifo_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got rd=%b we=%b busy=%b required 0 0 0", rd_now, bus.fifo_we, busy);
    end
    checks++;
    if (cur_chn !== 2'd3) begin errors++; $display("FAIL midrst_cur_chn got %0d required 3", cur_chn); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL midrst_words got %0d unwritten required 0", sb.size()); end
    wrst = 1'b0;
    src_clr = 1'b1;
    tick();
    src_clr = 1'b0;
    push_burst(0, 0, BURST_LEN);
    bus.chn_req = '1;
    wait_rd(10, "midrst_next");
    checks++;
    if (rd_now !== 4'b0001) begin errors++; $display("FAIL midrst_next_grant got %b required 0001", rd_now); end
    bus.chn_req = '0;
    count_burst(4'b0001, n);
    drain("midrst");
  endtask

  initial begin
    rst = 1'b1;
    wrst = 1'b0;
    en = 1'b0;
    src_clr = 1'b1;
    bus.chn_req = '0;
    bus.fifo_half_empty = 1'b1;
    rd_now = '0;
    rd_prev = '0;
    test_reset();
    test_single_burst();
    test_rotation();
    test_backpressure();
    test_enable();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
